// File: rtl/ula_pkg.sv
// Shared types and constants for the nibble-serial 74181 ALU.
// Optional overflow output is enabled by defining ULA_SEQ_OVF_EN.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_SUB_M1 = 4'b0110;
  localparam logic [3:0] S_XOR    = 4'b0110;

endpackage

// File: rtl/ula_seq_if.sv
// Handshake and data bundle for ula_seq.
// Carries ovf when ULA_SEQ_OVF_EN is defined.
interface ula_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             a_eq_b;
`ifdef ULA_SEQ_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, s, m, c_in,
    input  abort, out_ready,
    output in_ready, out_valid,
    output f, c_out, a_eq_b
`ifdef ULA_SEQ_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output in_valid, a, b, s, m, c_in,
    output abort, out_ready,
    input  in_ready, out_valid,
    input  f, c_out, a_eq_b
`ifdef ULA_SEQ_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/ula_74181_slice.sv
// One 4-bit 74181 slice, active-high data, active-low carries.
// Exports the bit-3 carry-in when ULA_SEQ_OVF_EN is defined.
module ula_74181_slice
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out
`ifdef ULA_SEQ_OVF_EN
  , output logic     c_msb
`endif
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] h;
  logic [4:0] c;

  // p/g are the inverted propagate/generate terms of the 74181
  assign p = ~(a | ({4{s[0]}} & b) | ({4{s[1]}} & ~b));
  assign g = ~(({4{s[2]}} & a & ~b) | ({4{s[3]}} & a & b));
  assign h = p ^ g;

  always_comb begin
    c    = '0;
    c[0] = ~c_in;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = ~g[i] | (~p[i] & c[i]);
    end
  end

  assign f     = m ? ~h : (h ^ c[3:0]);
  assign c_out = ~c[4];
`ifdef ULA_SEQ_OVF_EN
  assign c_msb = c[3];
`endif

endmodule

// File: rtl/ula_seq.sv
// Nibble-serial 74181 ALU: one 4-bit slice per clock, registered carry.
// Define ULA_SEQ_OVF_EN to add the signed-overflow output.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  ula_seq_if.slave io
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("ula_seq: WIDTH must be a multiple of 4, >= 4");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             c_out_q, c_out_d;
  logic             a_eq_b_q, a_eq_b_d;
`ifdef ULA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
  logic             sl_cmsb;
`endif

  logic [3:0] sl_a, sl_b, sl_f;
  logic       sl_co;
  logic       last;

  assign sl_a = a_q[{k_q, 2'b00} +: SLICE_W];
  assign sl_b = b_q[{k_q, 2'b00} +: SLICE_W];
  assign last = (k_q == KW'(NSLICE - 1));

  ula_74181_slice u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .s     (s_q),
    .m     (m_q),
    .c_in  (~carry_q),
    .f     (sl_f),
    .c_out (sl_co)
`ifdef ULA_SEQ_OVF_EN
    , .c_msb (sl_cmsb)
`endif
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    work_d   = work_q;
    f_d      = f_q;
    c_out_d  = c_out_q;
    a_eq_b_d = a_eq_b_q;
`ifdef ULA_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io.in_valid && !io.abort) begin
          a_d     = io.a;
          b_d     = io.b;
          s_d     = io.s;
          m_d     = io.m;
          carry_d = ~io.c_in;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (io.abort) begin
          state_d = IDLE;
        end else begin
          work_d[{k_q, 2'b00} +: SLICE_W] = sl_f;
          carry_d = ~sl_co;
          k_d     = k_q + KW'(1);
          if (last) begin
            // f only ever moves here, so no partial result leaks out
            f_d      = work_d;
            c_out_d  = m_q | sl_co;
            a_eq_b_d = &work_d;
`ifdef ULA_SEQ_OVF_EN
            ovf_d    = ~m_q & (sl_cmsb ^ ~sl_co);
`endif
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (io.abort || io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      work_q   <= '0;
      f_q      <= '0;
      c_out_q  <= 1'b1;
      a_eq_b_q <= 1'b0;
`ifdef ULA_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      work_q   <= work_d;
      f_q      <= f_d;
      c_out_q  <= c_out_d;
      a_eq_b_q <= a_eq_b_d;
`ifdef ULA_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.f         = f_q;
  assign io.c_out     = c_out_q;
  assign io.a_eq_b    = a_eq_b_q;
`ifdef ULA_SEQ_OVF_EN
  assign io.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq (WIDTH=16).
// Hand-computed 74181 results, latency, backpressure, abort, reset.
module tb_ula_seq;
  import ula_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  ula_seq_if #(.WIDTH(16)) bus ();

  ula_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  s,
    input  logic        m,
    input  logic        c,
    output int          lat
  );
    bus.a        = a;
    bus.b        = b;
    bus.s        = s;
    bus.m        = m;
    bus.c_in     = c;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.s         = '0;
    bus.m         = 1'b0;
    bus.c_in      = 1'b1;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0",
               bus.in_ready, bus.out_valid);
    end
    tests++;
    if (bus.f !== 16'h0000 || bus.c_out !== 1'b1 || bus.a_eq_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_out f=%h c=%b eq=%b want 0000/1/0",
               bus.f, bus.c_out, bus.a_eq_b);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int lat;
    run_op(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL add_latency got %0d want 4", lat);
    end
    tests++;
    if (bus.f !== 16'h2233 || bus.c_out !== 1'b1 || bus.a_eq_b !== 1'b0) begin
      fails++;
      $display("FAIL add f=%h c=%b eq=%b want 2233/1/0",
               bus.f, bus.c_out, bus.a_eq_b);
    end
    drain();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_drain in_ready=%b out_valid=%b want 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_equality();
    int lat;
    run_op(16'hBEEF, 16'hBEEF, S_SUB_M1, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 4 || bus.f !== 16'hFFFF ||
        bus.a_eq_b !== 1'b1 || bus.c_out !== 1'b1) begin
      fails++;
      $display("FAIL eq_same lat=%0d f=%h eq=%b c=%b want 4/FFFF/1/1",
               lat, bus.f, bus.a_eq_b, bus.c_out);
    end
    drain();
    run_op(16'hBEEF, 16'hBEEE, S_SUB_M1, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 4 || bus.f !== 16'h0000 ||
        bus.a_eq_b !== 1'b0 || bus.c_out !== 1'b0) begin
      fails++;
      $display("FAIL eq_diff lat=%0d f=%h eq=%b c=%b want 4/0000/0/0",
               lat, bus.f, bus.a_eq_b, bus.c_out);
    end
    drain();
  endtask

  task automatic test_wrap();
    int lat;
    run_op(16'hFFFF, 16'h0000, S_ADD, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4 || bus.f !== 16'h0000 || bus.c_out !== 1'b0) begin
      fails++;
      $display("FAIL wrap lat=%0d f=%h c=%b want 4/0000/0",
               lat, bus.f, bus.c_out);
    end
    drain();
  endtask

  task automatic test_logic_xor();
    int lat;
    run_op(16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b0, lat);
    tests++;
    if (lat !== 4 || bus.f !== 16'h0FF0 ||
        bus.c_out !== 1'b1 || bus.a_eq_b !== 1'b0) begin
      fails++;
      $display("FAIL xor lat=%0d f=%h c=%b eq=%b want 4/0FF0/1/0",
               lat, bus.f, bus.c_out, bus.a_eq_b);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_op(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, lat);
    bus.a        = 16'h5555;
    bus.b        = 16'h5555;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.f !== 16'h2233 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0) bad++;
    end
    tests++;
    if (lat !== 4 || bad !== 0) begin
      fails++;
      $display("FAIL bp_hold lat=%0d bad_cycles=%0d want 4/0", lat, bad);
    end
    bus.in_valid = 1'b0;
    drain();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.f !== 16'h2233) begin
      fails++;
      $display("FAIL bp_release rdy=%b vld=%b f=%h want 1/0/2233",
               bus.in_ready, bus.out_valid, bus.f);
    end
  endtask

  task automatic test_abort();
    int rose;
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h1111;
    step();
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle in_ready=%b want 1", bus.in_ready);
    end
    bus.s        = S_ADD;
    bus.m        = 1'b0;
    bus.c_in     = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.f !== 16'h2233) begin
      fails++;
      $display("FAIL abort_run rdy=%b vld=%b f=%h want 1/0/2233",
               bus.in_ready, bus.out_valid, bus.f);
    end
    rose = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_valid !== 1'b0) rose++;
    end
    tests++;
    if (rose !== 0) begin
      fails++;
      $display("FAIL abort_quiet out_valid_cycles=%0d want 0", rose);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.a        = 16'h1111;
    bus.b        = 16'h1111;
    bus.s        = S_ADD;
    bus.m        = 1'b0;
    bus.c_in     = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.f !== 16'h0000 || bus.c_out !== 1'b1 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_run f=%h c=%b vld=%b rdy=%b want 0000/1/0/1",
               bus.f, bus.c_out, bus.out_valid, bus.in_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    run_op(16'h1111, 16'h1111, S_ADD, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 4 || bus.f !== 16'h2222 || bus.c_out !== 1'b1) begin
      fails++;
      $display("FAIL after_reset lat=%0d f=%h c=%b want 4/2222/1",
               lat, bus.f, bus.c_out);
    end
    drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add();
    test_equality();
    test_wrap();
    test_logic_xor();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
